// File: rtl/posit_pkg.sv
// Shared types and constants for the posit rounding pipeline.
package posit_pkg;

   // Rounding mode as carried on in_mode.
   typedef enum logic {
      RND_RNE = 1'b0,  // round to nearest, ties to even
      RND_RTZ = 1'b1   // truncate toward zero
   } rnd_mode_e;

   // Largest positive posit of width n: 0 followed by n-1 ones.
   function automatic logic [63:0] posit_maxpos(input int n);
      return (64'd1 << (n - 1)) - 64'd1;
   endfunction

   // Smallest positive posit of any width: only the LSB set.
   function automatic logic [63:0] posit_minpos(input int n);
      return (n > 0) ? 64'd1 : 64'd0;
   endfunction

   // Not-a-Real: 1 followed by n-1 zeros.
   function automatic logic [63:0] posit_nar(input int n);
      return 64'd1 << (n - 1);
   endfunction

endpackage

// File: rtl/posit_regime_enc.sv
// Builds the unrounded posit body {regime, exponent, fraction} from an
// already clamped regime value. The body is left-aligned so the top N-1
// bits are the kept magnitude and everything below feeds guard/sticky.
module posit_regime_enc
   import posit_pkg::*;
#(
   parameter int N  = 32,
   parameter int ES = 2,
   parameter int RS = $clog2(N),
   parameter int FW = N
) (
   input  logic signed [RS+2:0]   k,
   input  logic [ES-1:0]          exp_fld,
   input  logic [FW-1:0]          frac,
   output logic [N+ES+FW-1:0]     field
);

   localparam int BW = N + ES + FW;

   logic          k_neg;
   logic [RS+2:0] run;
   logic [BW-1:0] tail;
   logic [BW-1:0] lead;

   // Regime run of identical bits, then the opposite terminator, then exp and frac.
   always_comb begin
      k_neg = k[RS+2];
      run   = k_neg ? (RS+3)'(-k) : (RS+3)'(k + 1);
      // The terminator is the complement of the run bit; a full-width run
      // pushes it into the guard position, which drops it from the word.
      tail  = {k_neg, exp_fld, frac, {(N-1){1'b0}}};
      lead  = k_neg ? '0 : ~({BW{1'b1}} >> run);
      field = lead | (tail >> run);
   end

endmodule

// File: rtl/posit_round_pipe.sv
// Two-stage posit encoder/rounder with valid/ready flow control.
// Stage 1 clamps the regime and lays out the unrounded body; stage 2
// rounds, saturates, applies the sign and handles the special values.
module posit_round_pipe
   import posit_pkg::*;
#(
   parameter int N  = 32,
   parameter int ES = 2,
   parameter int RS = $clog2(N),
   parameter int FW = N
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sign,
   input  logic                 in_zero,
   input  logic                 in_nar,
   input  logic signed [RS+2:0] in_k,
   input  logic [ES-1:0]        in_exp,
   input  logic [FW-1:0]        in_frac,
   input  logic                 in_sticky,
   input  logic                 in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_posit,
   output logic                 out_inexact
);

   localparam int            BW     = N + ES + FW;
   localparam int            KMAX   = N - 2;
   localparam logic [N-1:0]  MAXPOS = N'(posit_maxpos(N));
   localparam logic [N-1:0]  MINPOS = N'(posit_minpos(N));
   localparam logic [N-1:0]  NAR    = N'(posit_nar(N));

   // Nearest-even bumps on a guard bit that is not an exact tie to an even LSB.
   function automatic logic rnd_inc(input logic lsb, input logic grd,
                                    input logic stk, input logic mode);
      return (rnd_mode_e'(mode) == RND_RNE) && grd && (lsb || stk);
   endfunction

   // A nonzero magnitude never becomes NaR or zero after rounding.
   function automatic logic [N-1:0] sat_mag(input logic [N-1:0] sum);
      if (sum == NAR)
         return MAXPOS;
      if (sum == '0)
         return MINPOS;
      return sum;
   endfunction

   logic vld_p1, vld_p2;
   logic s1_load, s2_load;

   assign s2_load   = !vld_p2 || out_ready;
   assign s1_load   = !vld_p1 || s2_load;
   assign in_ready  = s1_load;
   assign out_valid = vld_p2;

   // ---------------- stage 1: clamp and lay out ----------------
   logic signed [RS+2:0] k_clamped;
   logic                 clamp_hi, clamp_lo;
   logic [BW-1:0]        field;

   // Out-of-range regimes are flagged and replaced by an in-range value.
   always_comb begin
      clamp_hi  = 1'b0;
      clamp_lo  = 1'b0;
      k_clamped = in_k;
      if (in_k > KMAX) begin
         clamp_hi  = 1'b1;
         k_clamped = (RS+3)'(KMAX);
      end else if (in_k < -KMAX) begin
         clamp_lo  = 1'b1;
         k_clamped = (RS+3)'(-KMAX);
      end
   end

   posit_regime_enc #(
      .N  (N),
      .ES (ES),
      .RS (RS),
      .FW (FW)
   ) u_regime_enc (
      .k       (k_clamped),
      .exp_fld (in_exp),
      .frac    (in_frac),
      .field   (field)
   );

   logic [BW-1:0] field_p1;
   logic          sticky_p1, sign_p1, zero_p1, nar_p1, mode_p1;
   logic          cmax_p1, cmin_p1;

   // Stage 1 occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vld_p1 <= 1'b0;
      else if (s1_load)
         vld_p1 <= in_valid;
   end

   // Stage 1 payload, captured whenever the stage is free to take a new operand.
   always_ff @(posedge clk) begin
      if (s1_load) begin
         field_p1  <= field;
         sticky_p1 <= in_sticky;
         sign_p1   <= in_sign;
         zero_p1   <= in_zero;
         nar_p1    <= in_nar;
         mode_p1   <= in_mode;
         cmax_p1   <= clamp_hi;
         cmin_p1   <= clamp_lo;
      end
   end

   // ---------------- stage 2: round, saturate, sign ----------------
   logic [N-2:0] kept;
   logic         grd, stk;
   logic [N-1:0] mag;
   logic [N-1:0] res_posit;
   logic         res_inexact;

   // Extract L/G/S from the body, round the magnitude and resolve specials.
   always_comb begin
      kept        = field_p1[BW-1 -: N-1];
      grd         = field_p1[BW-N];
      stk         = (|field_p1[BW-N-1:0]) | sticky_p1;
      mag         = sat_mag({1'b0, kept} + N'(rnd_inc(kept[0], grd, stk, mode_p1)));
      res_inexact = grd | stk;
      if (cmax_p1) begin
         mag         = MAXPOS;
         res_inexact = 1'b1;
      end else if (cmin_p1) begin
         mag         = MINPOS;
         res_inexact = 1'b1;
      end
      res_posit = sign_p1 ? (~mag + N'(1)) : mag;
      if (nar_p1) begin
         res_posit   = NAR;
         res_inexact = 1'b0;
      end else if (zero_p1) begin
         res_posit   = '0;
         res_inexact = 1'b0;
      end
   end

   // Stage 2 occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vld_p2 <= 1'b0;
      else if (s2_load)
         vld_p2 <= vld_p1;
   end

   // Output word; held while the downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_posit   <= '0;
         out_inexact <= 1'b0;
      end else if (s2_load && vld_p1) begin
         out_posit   <= res_posit;
         out_inexact <= res_inexact;
      end
   end

endmodule

// File: tb/tb_posit_round_pipe.sv
// Scoreboard bench for posit_round_pipe at N=32, ES=2, FW=32.
module tb_posit_round_pipe;

   localparam int N  = 32;
   localparam int ES = 2;
   localparam int RS = $clog2(N);
   localparam int FW = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic              in_sign, in_zero, in_nar;
   logic signed [RS+2:0] in_k;
   logic [ES-1:0]     in_exp;
   logic [FW-1:0]     in_frac;
   logic              in_sticky;
   logic              in_mode;
   logic              out_valid;
   logic              out_ready;
   logic [N-1:0]      out_posit;
   logic              out_inexact;

   posit_round_pipe #(
      .N  (N),
      .ES (ES),
      .RS (RS),
      .FW (FW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sign     (in_sign),
      .in_zero     (in_zero),
      .in_nar      (in_nar),
      .in_k        (in_k),
      .in_exp      (in_exp),
      .in_frac     (in_frac),
      .in_sticky   (in_sticky),
      .in_mode     (in_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_posit   (out_posit),
      .out_inexact (out_inexact)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          n_out  = 0;
   logic [32:0] sb_q[$];
   logic [32:0] cur_exp;
   logic        rand_done;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Reference encoder built as an explicit bit string: {inexact, posit}.
   function automatic logic [32:0] ref_enc(input logic s, input logic z, input logic n,
                                           input int k, input logic [1:0] e,
                                           input logic [31:0] f, input logic st,
                                           input logic m);
      bit          b[$];
      logic [31:0] mag;
      logic        g, sb, inx;
      if (n) return {1'b0, 32'h8000_0000};
      if (z) return 33'd0;
      if (k > 30) begin
         mag = 32'h7FFF_FFFF;
         inx = 1'b1;
      end else if (k < -30) begin
         mag = 32'h0000_0001;
         inx = 1'b1;
      end else begin
         if (k >= 0) begin
            for (int i = 0; i <= k; i++) b.push_back(1'b1);
            b.push_back(1'b0);
         end else begin
            for (int i = 0; i < -k; i++) b.push_back(1'b0);
            b.push_back(1'b1);
         end
         for (int i = 1; i >= 0; i--) b.push_back(e[i]);
         for (int i = 31; i >= 0; i--) b.push_back(f[i]);
         mag = 32'd0;
         for (int i = 0; i < 31; i++) mag = {mag[30:0], b[i]};
         g  = b[31];
         sb = st;
         for (int i = 32; i < b.size(); i++) sb = sb | b[i];
         inx = g | sb;
         if (!m && g && (mag[0] || sb)) mag = mag + 32'd1;
         if (mag == 32'h8000_0000) mag = 32'h7FFF_FFFF;
      end
      return {inx, s ? (~mag + 32'd1) : mag};
   endfunction

   // Scoreboard: compare the head against whatever is presented, pop on transfer,
   // push accepted stimulus. Sampled 1 time unit before each rising edge.
   always begin
      @(negedge clk);
      #4;
      if (rst_n) begin
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               check_val("spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
               check_val($sformatf("posit#%0d", n_out), {32'd0, out_posit}, {32'd0, sb_q[0][31:0]});
               check_val($sformatf("inexact#%0d", n_out), {63'd0, out_inexact}, {63'd0, sb_q[0][32]});
               if (out_ready) begin
                  void'(sb_q.pop_front());
                  n_out++;
               end
            end
         end
         if (in_valid && in_ready) sb_q.push_back(cur_exp);
      end
   end

   task automatic send(input logic s, input logic z, input logic n, input int k,
                       input logic [1:0] e, input logic [31:0] f, input logic st,
                       input logic m, input logic [32:0] want);
      bit ok;
      @(negedge clk);
      in_sign   = s;
      in_zero   = z;
      in_nar    = n;
      in_k      = (RS+3)'(k);
      in_exp    = e;
      in_frac   = f;
      in_sticky = st;
      in_mode   = m;
      cur_exp   = want;
      in_valid  = 1'b1;
      ok        = 1'b0;
      for (int t = 0; t < 50; t++) begin
         #4;
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check_val("in_ready_timeout", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic send_ref(input logic s, input logic z, input logic n, input int k,
                           input logic [1:0] e, input logic [31:0] f, input logic st,
                           input logic m);
      send(s, z, n, k, e, f, st, m, ref_enc(s, z, n, k, e, f, st, m));
   endtask

   task automatic send_rand();
      int          k;
      logic        s, z, n, st, m;
      logic [1:0]  e;
      logic [31:0] f;
      k  = int'($urandom_range(68)) - 34;
      s  = 1'($urandom);
      z  = ($urandom_range(15) == 0);
      n  = ($urandom_range(15) == 0);
      st = 1'($urandom);
      m  = 1'($urandom);
      e  = 2'($urandom);
      f  = $urandom;
      send_ref(s, z, n, k, e, f, st, m);
   endtask

   task automatic go_idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int t = 0; t < 100; t++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      check_val(tag, 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_zero   = 1'b0;
      in_nar    = 1'b0;
      in_k      = '0;
      in_exp    = '0;
      in_frac   = '0;
      in_sticky = 1'b0;
      in_mode   = 1'b0;
      out_ready = 1'b1;
      cur_exp   = '0;
      rand_done = 1'b0;

      #2;
      check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_val("rst_out_posit", {32'd0, out_posit}, 64'd0);
      check_val("rst_out_inexact", {63'd0, out_inexact}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Directed values with literal expectations.
      send(0, 0, 0,   0, 2'd0, 32'h0000_0000, 0, 0, {1'b0, 32'h4000_0000});
      send(1, 0, 0,   0, 2'd0, 32'h0000_0000, 0, 0, {1'b0, 32'hC000_0000});
      send(0, 0, 0,   0, 2'd0, 32'hFFFF_FFFF, 0, 0, {1'b1, 32'h4800_0000});
      send(0, 0, 0,   0, 2'd0, 32'hFFFF_FFFF, 0, 1, {1'b1, 32'h47FF_FFFF});
      send(0, 0, 0,  40, 2'd0, 32'h0000_0000, 0, 0, {1'b1, 32'h7FFF_FFFF});
      send(0, 0, 0, -40, 2'd0, 32'h0000_0000, 0, 0, {1'b1, 32'h0000_0001});
      send(1, 0, 0, -40, 2'd0, 32'h0000_0000, 0, 0, {1'b1, 32'hFFFF_FFFF});
      send(1, 1, 1,   3, 2'd1, 32'h1234_5678, 1, 0, {1'b0, 32'h8000_0000});
      send(1, 1, 0,   3, 2'd1, 32'h1234_5678, 1, 0, {1'b0, 32'h0000_0000});
      // Range edges, carry into regime, sticky-only ties.
      send_ref(0, 0, 0,  30, 2'd3, 32'hFFFF_FFFF, 1, 0);
      send_ref(0, 0, 0,  29, 2'd3, 32'hFFFF_FFFF, 0, 0);
      send_ref(0, 0, 0, -30, 2'd3, 32'h0000_0000, 0, 0);
      send_ref(1, 0, 0, -30, 2'd2, 32'h0000_0000, 0, 0);
      send_ref(0, 0, 0,  -1, 2'd0, 32'h0000_0030, 0, 0);
      send_ref(0, 0, 0,  -1, 2'd0, 32'h0000_0010, 1, 0);
      send_ref(0, 0, 0,   2, 2'd3, 32'hFFFF_FFFF, 0, 1);
      send_ref(0, 0, 0,  31, 2'd0, 32'h0000_0000, 0, 0);
      send_ref(0, 0, 0, -31, 2'd0, 32'h0000_0000, 0, 0);
      go_idle();
      drain("drain_directed");

      // Random operands under random downstream backpressure.
      fork
         begin
            for (int i = 0; i < 60; i++) send_rand();
            go_idle();
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               out_ready = ($urandom_range(3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain("drain_random");

      // Eight back-to-back operands, downstream stalled on cycles 3..5.
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 8; i++) send_rand();
            go_idle();
         end
         begin
            repeat (4) @(negedge clk);
            out_ready = 1'b0;
            repeat (2) @(negedge clk);
            #4;
            check_val("in_ready_full", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain("drain_stream");

      // Reset with two operands in flight: both must vanish.
      send_ref(0, 0, 0, 5, 2'd1, 32'hDEAD_BEEF, 0, 0);
      send_ref(1, 0, 0, -5, 2'd2, 32'h0BAD_F00D, 1, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check_val("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check_val("midrst_out_posit", {32'd0, out_posit}, 64'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      repeat (10) @(negedge clk);
      check_val("midrst_no_output", {63'd0, out_valid}, 64'd0);

      // Pipeline still works after the mid-run reset.
      send(0, 0, 0, 0, 2'd0, 32'h0000_0000, 0, 0, {1'b0, 32'h4000_0000});
      go_idle();
      drain("drain_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
